// File: rtl/snd.sv
// UART transmitter: accepts one byte over a four-phase Req/Ack handshake and
// sends it as an 8-N-1 frame on RxD, LSB first, CLKS_PER_BIT clocks per bit.
module snd #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       Req,
  input  logic [7:0] char,
  output logic       RxD,
  output logic       Ack
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt,   w_cnt_nxt;
  logic [2:0]      r_bit,   w_bit_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            r_rxd,   w_rxd_nxt;
  logic            r_ack,   w_ack_nxt;
  logic            w_tick;

  assign w_tick = (r_cnt == LAST);
  assign RxD    = r_rxd;
  assign Ack    = r_ack;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_rxd   <= 1'b1;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_rxd   <= w_rxd_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  // Outputs are computed for the next state so RxD/Ack change on the same
  // edge as the state transition while remaining registered.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_rxd_nxt   = r_rxd;
    w_ack_nxt   = r_ack;
    case (r_state)
      IDLE: begin
        w_rxd_nxt = 1'b1;
        w_ack_nxt = 1'b0;
        if (Req) begin
          w_state_nxt = START;
          w_cnt_nxt   = '0;
          w_shift_nxt = char;
          w_rxd_nxt   = 1'b0;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_rxd_nxt   = r_shift[0];
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_cnt_nxt = '0;
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
            w_rxd_nxt   = 1'b1;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_rxd_nxt   = r_shift[1];
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      STOP: begin
        if (w_tick) begin
          w_state_nxt = DONE;
          w_cnt_nxt   = '0;
          w_ack_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DONE: begin
        w_rxd_nxt = 1'b1;
        if (!Req) begin
          w_state_nxt = IDLE;
          w_ack_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_rxd_nxt   = 1'b1;
        w_ack_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_snd.sv
// Self-checking bench for snd: frames are compared cycle by cycle against a
// timing model derived from the frame layout (start, 8 data LSB first, stop).
module tb_snd;

  localparam int C = 8;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       Req = 1'b0;
  logic [7:0] char = 8'h00;
  logic       RxD;
  logic       Ack;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  snd #(.CLKS_PER_BIT(C)) dut (
    .clk  (clk),
    .clr  (clr),
    .Req  (Req),
    .char (char),
    .RxD  (RxD),
    .Ack  (Ack)
  );

  always #10 clk = ~clk;

  // Expected line level j edges after the acceptance edge.
  function automatic logic line_model(input logic [7:0] data, input int j);
    int idx;
    idx = j / C;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return data[idx-1];
    return 1'b1;
  endfunction

  // Sends one frame; Req stays high for req_hold edges (starting with E0).
  // If still high when Ack rises, Ack must stay up for extra cycles.
  task automatic run_frame(input logic [7:0] data, input int req_hold,
                           input bit scramble_char, input string name);
    @(negedge clk);
    char = data;
    Req  = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 10*C; j++) begin
      @(negedge clk);
      n_total++;
      if (RxD !== line_model(data, j)) begin
        $display("FAIL %s line j=%0d got %b want %b", name, j, RxD, line_model(data, j));
      end else n_pass++;
      n_total++;
      if (Ack !== 1'b0) begin
        $display("FAIL %s ack_early j=%0d got %b want 0", name, j, Ack);
      end else n_pass++;
      if (j + 1 == req_hold) Req = 1'b0;
      if (scramble_char && j == 0) char = 8'h00;
      else if (j > 0) char = 8'($urandom);
    end
    @(negedge clk);
    n_total++;
    if (Ack !== 1'b1 || RxD !== 1'b1) begin
      $display("FAIL %s ack_rise got ack=%b rxd=%b want ack=1 rxd=1", name, Ack, RxD);
    end else n_pass++;
    if (Req) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        n_total++;
        if (Ack !== 1'b1 || RxD !== 1'b1) begin
          $display("FAIL %s ack_hold k=%0d got ack=%b rxd=%b want 1 1", name, k, Ack, RxD);
        end else n_pass++;
      end
      Req = 1'b0;
      @(negedge clk);
    end else begin
      @(negedge clk);
    end
    n_total++;
    if (Ack !== 1'b0 || RxD !== 1'b1) begin
      $display("FAIL %s ack_fall got ack=%b rxd=%b want ack=0 rxd=1", name, Ack, RxD);
    end else n_pass++;
  endtask

  task automatic test_reset;
    Req  = 1'b1;
    clr  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      char = 8'($urandom);
      @(negedge clk);
      n_total++;
      if (RxD !== 1'b1 || Ack !== 1'b0) begin
        $display("FAIL reset_hold k=%0d got rxd=%b ack=%b want 1 0", k, RxD, Ack);
      end else n_pass++;
    end
    Req = 1'b0;
    @(negedge clk);
    #10 clr = 1'b1;
    @(negedge clk);
    n_total++;
    if (RxD !== 1'b1 || Ack !== 1'b0) begin
      $display("FAIL reset_release got rxd=%b ack=%b want 1 0", RxD, Ack);
    end else n_pass++;
  endtask

  task automatic test_basic;
    run_frame(8'hDB, 100, 1'b0, "basic");
  endtask

  task automatic test_data_hold;
    run_frame(8'hDB, 3, 1'b1, "data_hold");
  endtask

  task automatic test_early_drop;
    run_frame(8'h55, 1, 1'b0, "early_drop");
  endtask

  task automatic test_back_to_back;
    run_frame(8'h01, 2, 1'b0, "b2b_first");
    run_frame(8'h80, 2, 1'b0, "b2b_second");
  endtask

  task automatic test_held_req;
    run_frame(8'($urandom), 10*C + 20, 1'b0, "held_req");
  endtask

  task automatic test_random;
    for (int n = 0; n < 5; n++)
      run_frame(8'($urandom), 1 + int'($urandom_range(0, 10*C + 4)), 1'b0, "random");
  endtask

  task automatic test_mid_reset;
    int wait_cycles;
    wait_cycles = int'($urandom_range(3, 9*C));
    @(negedge clk);
    char = 8'h00;
    Req  = 1'b1;
    @(posedge clk);
    repeat (wait_cycles) @(posedge clk);
    #3 clr = 1'b0;
    #1;
    n_total++;
    if (RxD !== 1'b1 || Ack !== 1'b0) begin
      $display("FAIL mid_reset got rxd=%b ack=%b want 1 0", RxD, Ack);
    end else n_pass++;
    Req = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    n_total++;
    if (RxD !== 1'b1 || Ack !== 1'b0) begin
      $display("FAIL mid_reset_release got rxd=%b ack=%b want 1 0", RxD, Ack);
    end else n_pass++;
    run_frame(8'($urandom), 4, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_data_hold();
    test_early_drop();
    test_back_to_back();
    test_held_req();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
